// File: rtl/spi_cmd_regfile_pkg.sv
// Shared constants and types for the SPI command/register-file block.
// Defaults mirror the SPI slave's word width; override at the top only in lockstep.
package spi_cmd_regfile_pkg;

   localparam int                 DEF_SPI_WIDTH  = 16;
   localparam int                 DEF_ADDR_WIDTH = 8;
   localparam int                 DEF_REG_COUNT  = 16;
   localparam logic [15:0]        DEF_ID_VALUE   = 16'hA55A;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

endpackage

// File: rtl/spi_cmd_regfile_if.sv
// Link between the SPI slave (master side here) and the command register file.
interface spi_cmd_regfile_if #(
   parameter int SPI_WIDTH = 16
);
   logic                 nSSIN;
   logic                 wordToggleIN;
   logic [SPI_WIDTH-1:0] rxDataIN;
   logic [SPI_WIDTH-1:0] txDataOUT;

   modport master (output nSSIN, wordToggleIN, rxDataIN, input  txDataOUT);
   modport slave  (input  nSSIN, wordToggleIN, rxDataIN, output txDataOUT);
endinterface

// File: rtl/spi_cmd_regfile_sync2.sv
// Two-flop synchroniser for asynchronous single-bit SPI control signals.
module spi_sync2 (
   input  logic clkIN,
   input  logic reset_spi,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clkIN or posedge reset_spi) begin
      if (reset_spi) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/spi_cmd_regfile.sv
// Decodes SPI command/address + data words into a control register file,
// and returns read data to the SPI slave's parallel load input.
module spi_cmd_regfile
   import spi_cmd_regfile_pkg::*;
#(
   parameter int                   SPI_WIDTH  = DEF_SPI_WIDTH,
   parameter int                   ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                   REG_COUNT  = DEF_REG_COUNT,
   parameter logic [SPI_WIDTH-1:0] ID_VALUE   = DEF_ID_VALUE
)(
   input  logic                            clkIN,
   input  logic                            reset_spi,
   spi_cmd_regfile_if.slave                spi,
   output logic [REG_COUNT*SPI_WIDTH-1:0]  regsOUT,
   output logic                            wrStrobeOUT,
   output logic [ADDR_WIDTH-1:0]           wrAddrOUT,
   output logic [7:0]                      frameCountOUT
);
   localparam int RNW   = SPI_WIDTH - 1;
   localparam int IDX_W = $clog2(REG_COUNT);

   state_t state, state_nx;
   logic   nss_s, nss_h, tog_s, tog_h;
   logic   nss_fall, nss_rise, word_stb;
   logic   cmd_take, data_take, frame_inc, wr_hit;
   logic   rnw_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
   logic [REG_COUNT-1:1][SPI_WIDTH-1:0] regs_q;
   logic [REG_COUNT-1:0][SPI_WIDTH-1:0] regs_view;

   spi_sync2 u_sync_nss (.clkIN(clkIN), .reset_spi(reset_spi), .d(spi.nSSIN),        .q(nss_s));
   spi_sync2 u_sync_tog (.clkIN(clkIN), .reset_spi(reset_spi), .d(spi.wordToggleIN), .q(tog_s));

   always_ff @(posedge clkIN or posedge reset_spi) begin
      if (reset_spi) begin
         nss_h <= 1'b0;
         tog_h <= 1'b0;
      end else begin
         nss_h <= nss_s;
         tog_h <= tog_s;
      end
   end

   assign nss_fall = nss_h & ~nss_s;
   assign nss_rise = ~nss_h & nss_s;
   // Qualify with either nSS sample low so a word completing on the rising edge is kept.
   assign word_stb = (tog_s ^ tog_h) & ~(nss_s & nss_h);

   assign regs_view = {regs_q, ID_VALUE};
   assign regsOUT   = regs_view;
   assign addr_inc  = addr_q + 1'b1;
   assign wr_hit    = data_take & ~rnw_q & (addr_q != '0) & (int'(addr_q) < REG_COUNT);

   function automatic logic [SPI_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
      rd = '0;
      if (int'(a) < REG_COUNT) rd = regs_view[a[IDX_W-1:0]];
   endfunction

   always_ff @(posedge clkIN or posedge reset_spi) begin
      if (reset_spi) state <= IDLE;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cmd_take  = 1'b0;
      data_take = 1'b0;
      frame_inc = 1'b0;
      case (state)
         IDLE: if (nss_fall) state_nx = CMD;
         CMD:  if (word_stb) begin
                  cmd_take = 1'b1;
                  state_nx = DATA;
               end
         DATA: data_take = word_stb;
         default: state_nx = IDLE;
      endcase
      if (nss_rise) begin
         state_nx  = IDLE;
         frame_inc = (state == DATA);
      end
   end

   always_ff @(posedge clkIN or posedge reset_spi) begin
      if (reset_spi) begin
         rnw_q         <= 1'b0;
         addr_q        <= '0;
         spi.txDataOUT <= '0;
         regs_q        <= '0;
         wrStrobeOUT   <= 1'b0;
         wrAddrOUT     <= '0;
         frameCountOUT <= '0;
      end else begin
         wrStrobeOUT <= 1'b0;
         if (cmd_take) begin
            rnw_q  <= spi.rxDataIN[RNW];
            addr_q <= spi.rxDataIN[ADDR_WIDTH-1:0];
            if (spi.rxDataIN[RNW]) spi.txDataOUT <= rd(spi.rxDataIN[ADDR_WIDTH-1:0]);
         end
         if (data_take) begin
            addr_q <= addr_inc;
            if (rnw_q) spi.txDataOUT <= rd(addr_inc);
         end
         if (wr_hit) begin
            wrStrobeOUT <= 1'b1;
            wrAddrOUT   <= addr_q;
         end
         for (int i = 1; i < REG_COUNT; i++)
            if (wr_hit && addr_q == ADDR_WIDTH'(i)) regs_q[i] <= spi.rxDataIN;
         if (frame_inc) frameCountOUT <= frameCountOUT + 8'd1;
      end
   end
endmodule
